// File: rtl/ascon_word_loader.sv
// Collects a 12-word key/nonce/AD/plaintext stream into the parallel Ascon-128 input buses.
// A complete frame is held for the core; a stalled partial frame is dropped after IDLE_TIMEOUT idle cycles.
module ascon_word_loader #(
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          core_done,
  output logic [127:0]  SK,
  output logic [127:0]  N,
  output logic [63:0]   A,
  output logic [63:0]   P,
  output logic          frame_valid,
  output logic          start,
  output logic          err_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [15:0] TIMEOUT_LIM = 16'(IDLE_TIMEOUT);

  logic [1:0]  state;
  logic [3:0]  wi;
  logic [15:0] idle_cnt;
  logic [15:0] idle_cnt_inc;
  logic        accept;
  logic        timeout_hit;

  assign accept       = in_valid & in_ready;
  assign idle_cnt_inc = (idle_cnt == 16'hFFFF) ? idle_cnt : idle_cnt + 16'd1;
  // The timeout decision looks at the count this idle cycle would produce, so an
  // accept arriving on that same cycle takes priority.
  assign timeout_hit  = (TIMEOUT_LIM != 16'd0) && (idle_cnt_inc >= TIMEOUT_LIM);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= S_IDLE;
      wi          <= 4'd0;
      idle_cnt    <= 16'd0;
      SK          <= '0;
      N           <= '0;
      A           <= '0;
      P           <= '0;
      in_ready    <= 1'b0;
      frame_valid <= 1'b0;
      start       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      start       <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE, S_FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            case (wi)
              4'd0:    SK[127:96] <= in_data;
              4'd1:    SK[95:64]  <= in_data;
              4'd2:    SK[63:32]  <= in_data;
              4'd3:    SK[31:0]   <= in_data;
              4'd4:    N[127:96]  <= in_data;
              4'd5:    N[95:64]   <= in_data;
              4'd6:    N[63:32]   <= in_data;
              4'd7:    N[31:0]    <= in_data;
              4'd8:    A[63:32]   <= in_data;
              4'd9:    A[31:0]    <= in_data;
              4'd10:   P[63:32]   <= in_data;
              4'd11:   P[31:0]    <= in_data;
              default: ;
            endcase
            idle_cnt <= 16'd0;
            if (wi == 4'd11) begin
              state       <= S_FULL;
              wi          <= 4'd0;
              in_ready    <= 1'b0;
              frame_valid <= 1'b1;
              start       <= 1'b1;
            end else begin
              state <= S_FILL;
              wi    <= wi + 4'd1;
            end
          end else if (state == S_FILL) begin
            if (timeout_hit) begin
              state       <= S_IDLE;
              wi          <= 4'd0;
              idle_cnt    <= 16'd0;
              err_timeout <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt_inc;
            end
          end
        end
        S_FULL: begin
          if (core_done) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            frame_valid <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          wi          <= 4'd0;
          idle_cnt    <= 16'd0;
          in_ready    <= 1'b1;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
